// File: rtl/maze_memory.sv
// maze_memory: wall-bit map storage with a streamed load phase and a serve
// phase that answers registered reads. Optional visited tracking (marks,
// distinct-visit counter, wall-hit error flag) is built when the macro
// MAZE_VISIT_TRACE_EN is defined; otherwise those outputs are tied to zero.
module maze_memory #(
    parameter int maze_width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [maze_width-1:0] row,
    input  logic [maze_width-1:0] col,
    input  logic                  maze_oe,
    input  logic                  maze_we,
    output logic                  maze_in,
    input  logic                  load_valid,
    input  logic                  load_data,
    output logic                  load_ready,
    input  logic                  load_start,
    output logic                  load_done,
    output logic [15:0]           visit_count,
    output logic                  wall_write_err
);

    localparam int unsigned IDX_W = 2 * maze_width;
    localparam int unsigned CELLS = 1 << IDX_W;

    typedef enum logic {
        LOAD,
        SERVE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] sel_idx;
    logic             beat;
    logic             wall_mem [CELLS];

    // Row-major cell address of the selected [row,col]
    assign sel_idx = {row, col};
    // A stream beat is taken only in LOAD and never alongside a restart
    assign beat    = (state_q == LOAD) && load_valid && !load_start;

    // Next-state, load counter and handshake outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        load_done  = 1'b0;
        case (state_q)
            LOAD: begin
                load_ready = 1'b1;
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = SERVE;
                    end
                end
            end
            SERVE: begin
                load_done = 1'b1;
            end
        endcase
        if (load_start) begin
            state_d = LOAD;
            cnt_d   = '0;
        end
    end

    // State and load-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered read port; reads outside SERVE report a wall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maze_in <= 1'b0;
        end else if (maze_oe) begin
            maze_in <= (state_q == SERVE) ? wall_mem[sel_idx] : 1'b1;
        end
    end

    // Wall map storage, written only by accepted stream beats
    always_ff @(posedge clk) begin
        if (beat) begin
            wall_mem[cnt_q] <= load_data;
        end
    end

`ifdef MAZE_VISIT_TRACE_EN
    logic visited_mem [CELLS];
    logic mark;

    assign mark = (state_q == SERVE) && maze_we && !load_start;

    // Visited flags: cleared cell-by-cell as the map streams in, set by marks
    always_ff @(posedge clk) begin
        if (beat) begin
            visited_mem[cnt_q] <= 1'b0;
        end else if (mark) begin
            visited_mem[sel_idx] <= 1'b1;
        end
    end

    // Distinct-visit counter (saturating) and sticky wall-hit flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            visit_count    <= '0;
            wall_write_err <= 1'b0;
        end else if (load_start) begin
            visit_count    <= '0;
            wall_write_err <= 1'b0;
        end else if (mark) begin
            if (!visited_mem[sel_idx] && (visit_count != '1)) begin
                visit_count <= visit_count + 16'd1;
            end
            if (wall_mem[sel_idx]) begin
                wall_write_err <= 1'b1;
            end
        end
    end
`else
    logic unused_we;

    assign unused_we      = maze_we;
    assign visit_count    = '0;
    assign wall_write_err = 1'b0;
`endif

endmodule

// File: tb/tb_maze_memory.sv
// tb_maze_memory: directed + randomized bench for maze_memory (maze_width=2)
// against a cell-array reference model. Visit-tracking expectations follow
// whether MAZE_VISIT_TRACE_EN is defined for the build.
module tb_maze_memory;

    localparam int W = 2;
    localparam int N = 16;
`ifdef MAZE_VISIT_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] row, col;
    logic         maze_oe, maze_we;
    logic         maze_in;
    logic         load_valid, load_data, load_ready;
    logic         load_start, load_done;
    logic [15:0]  visit_count;
    logic         wall_write_err;

    maze_memory #(.maze_width(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .row            (row),
        .col            (col),
        .maze_oe        (maze_oe),
        .maze_we        (maze_we),
        .maze_in        (maze_in),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .load_start     (load_start),
        .load_done      (load_done),
        .visit_count    (visit_count),
        .wall_write_err (wall_write_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit m_wall [N];
    bit m_vis  [N];
    bit m_serve;
    int m_cnt;
    int m_vc;
    bit m_err;
    bit m_q;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_serve = 1'b0;
        m_cnt   = 0;
        m_vc    = 0;
        m_err   = 1'b0;
        m_q     = 1'b0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven
    task automatic model_edge();
        int idx;
        bit was_serve;
        idx = row * N / (1 << W) + col;
        idx = int'(row) * (1 << W) + int'(col);
        if (!rst_n) begin
            model_reset();
            return;
        end
        was_serve = m_serve;
        if (maze_oe) m_q = was_serve ? m_wall[idx] : 1'b1;
        if (load_start) begin
            m_serve = 1'b0;
            m_cnt   = 0;
            m_vc    = 0;
            m_err   = 1'b0;
        end else if (!was_serve) begin
            if (load_valid) begin
                m_wall[m_cnt] = load_data;
                m_vis[m_cnt]  = 1'b0;
                if (m_cnt == N - 1) m_serve = 1'b1;
                m_cnt = (m_cnt + 1) % N;
            end
        end else if (TRACE && maze_we) begin
            if (!m_vis[idx] && m_vc < 65535) m_vc = m_vc + 1;
            m_vis[idx] = 1'b1;
            if (m_wall[idx]) m_err = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_maze_in"}, 16'(maze_in), 16'(m_q));
        chk({tag, "_done"},    16'(load_done), 16'(m_serve));
        chk({tag, "_ready"},   16'(load_ready), 16'(!m_serve));
        chk({tag, "_vcount"},  visit_count, 16'(m_vc));
        chk({tag, "_werr"},    16'(wall_write_err), 16'(m_err));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        maze_oe    = 1'b0;
        maze_we    = 1'b0;
        load_valid = 1'b0;
        load_data  = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic load_map(input logic [15:0] pat);
        for (int i = 0; i < N; i++) begin
            load_valid = 1'b1;
            load_data  = pat[15 - i];
            tick("load");
            if (i == N - 2) chk("done_before_last", 16'(load_done), 16'd0);
        end
        load_valid = 1'b0;
        chk("done_after_16", 16'(load_done), 16'd1);
        chk("ready_after_16", 16'(load_ready), 16'd0);
    endtask

    task automatic rd(input int r, input int c);
        row = W'(r); col = W'(c); maze_oe = 1'b1;
        tick("rd");
        maze_oe = 1'b0;
    endtask

    task automatic mark(input int r, input int c);
        row = W'(r); col = W'(c); maze_we = 1'b1;
        tick("mark");
        maze_we = 1'b0;
    endtask

    task automatic random_serve(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            row        = W'($urandom);
            col        = W'($urandom);
            maze_oe    = 1'($urandom);
            maze_we    = 1'($urandom);
            load_valid = 1'($urandom);
            load_data  = 1'($urandom);
            tick("rand_serve");
        end
        idle_inputs();
    endtask

    initial begin
        int taken;
        logic [15:0] pat;
        pat = 16'hF99F;
        for (int i = 0; i < N; i++) begin
            m_wall[i] = 1'b0;
            m_vis[i]  = 1'b0;
        end
        idle_inputs();
        row   = '0;
        col   = '0;
        rst_n = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        tick("reset_hold");
        rst_n = 1'b1;

        // Fixed map, directed reads and marks
        load_map(pat);
        rd(1, 1);
        chk("rd_1_1", 16'(maze_in), 16'd0);
        rd(0, 2);
        chk("rd_0_2", 16'(maze_in), 16'd1);
        tick("hold");
        chk("rd_hold", 16'(maze_in), 16'd1);
        mark(1, 1);
        mark(1, 1);
        mark(1, 2);
        chk("vc_two", visit_count, TRACE ? 16'd2 : 16'd0);
        chk("werr_clear", 16'(wall_write_err), 16'd0);
        mark(0, 0);
        chk("vc_three", visit_count, TRACE ? 16'd3 : 16'd0);
        chk("werr_set", 16'(wall_write_err), TRACE ? 16'd1 : 16'd0);
        row = 2'd2; col = 2'd1; maze_oe = 1'b1; maze_we = 1'b1;
        tick("oe_we_same");
        idle_inputs();
        rd(2, 1);
        chk("wall_kept", 16'(maze_in), 16'd0);
        random_serve(40);

        // Restart a load, abort it after 5 gapped beats, then reload
        load_start = 1'b1;
        tick("restart");
        load_start = 1'b0;
        chk("restart_vc", visit_count, 16'd0);
        taken = 0;
        for (int i = 0; i < 60 && taken < 5; i++) begin
            load_valid = 1'($urandom);
            load_data  = 1'($urandom);
            if (load_valid) taken++;
            tick("partial");
        end
        chk("partial_beats", 16'(taken), 16'd5);
        load_valid = 1'b0;
        rd(0, 0);
        chk("rd_during_load", 16'(maze_in), 16'd1);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 1'b0;
        tick("restart_beat");
        idle_inputs();
        taken = 0;
        for (int i = 0; i < 200 && taken < N; i++) begin
            chk("not_done_early", 16'(load_done), 16'd0);
            load_valid = 1'($urandom);
            load_data  = pat[15 - taken];
            if (load_valid) taken++;
            tick("reload");
        end
        load_valid = 1'b0;
        chk("reload_beats", 16'(taken), 16'd16);
        chk("reload_done", 16'(load_done), 16'd1);
        mark(1, 1);
        mark(1, 2);
        mark(3, 3);
        chk("vc_reload", visit_count, TRACE ? 16'd3 : 16'd0);
        rd(0, 1);

        // Asynchronous reset mid-serve
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_q", 16'(maze_in), 16'd0);
        chk("async_rst_ready", 16'(load_ready), 16'd1);
        tick("rst_low");
        rst_n = 1'b1;

        // Random map after reset, then random service
        load_map(16'($urandom));
        random_serve(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
